// File: rtl/key_reduce_stage.sv
`default_nettype none
// ============================================================================
// Module      : key_reduce_stage
// Description : Merges consecutive same-key FIFO words into {key, sum, count}
//               results with a valid/ready output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module key_reduce_stage #(
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 48,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] fifo_data,
    input  logic                          fifo_empty,
    output logic                          fifo_consume,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [KEY_WIDTH-1:0]          out_key,
    output logic [VAL_WIDTH-1:0]          out_sum,
    output logic [CNT_WIDTH-1:0]          out_count,
    output logic                          busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VAL_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   valid_q;

    logic                   w_consume;
    logic                   w_load;
    logic [KEY_WIDTH-1:0]   w_head_key;
    logic [VAL_WIDTH-1:0]   w_head_val;

    assign w_head_key = fifo_data[KEY_WIDTH+VAL_WIDTH-1:VAL_WIDTH];
    assign w_head_val = fifo_data[VAL_WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        w_consume = 1'b0;
        w_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_load  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (flush || (cnt_q == CNT_MAX)) begin
                    state_d = S_EMIT;
                end else if (!fifo_empty) begin
                    if (w_head_key != key_q) begin
                        state_d = S_EMIT;
                    end else begin
                        w_consume = 1'b1;
                        sum_d     = sum_q + w_head_val;
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end
            end
            S_EMIT: begin
                // Reloading from the head on the handshake avoids an idle bubble.
                if (out_ready) begin
                    if (!fifo_empty) begin
                        w_load  = 1'b1;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_load) begin
            w_consume = 1'b1;
            key_d     = w_head_key;
            sum_d     = w_head_val;
            cnt_d     = CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == S_EMIT);
        end
    end

    assign fifo_consume = w_consume && !rst;
    assign out_valid    = valid_q;
    assign out_key      = key_q;
    assign out_sum      = sum_q;
    assign out_count    = cnt_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/key_reduce_stage.md
KEY_REDUCE_STAGE -- requirements
Module: key_reduce_stage

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default 16, meaning particle-key field width.
REQ-002 SHALL have parameter VAL_WIDTH, default 48, meaning signed partial-value field width.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning merge-counter width; CNT_MAX = 2^CNT_WIDTH-1.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port fifo_data, input, KEY_WIDTH+VAL_WIDTH, upstream FIFO head word {key[MSBs], val[LSBs]}, valid whenever fifo_empty=0 (show-ahead).
REQ-007 SHALL have port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-008 SHALL have port fifo_consume, output, 1, pop strobe to the upstream FIFO.
REQ-009 SHALL have port flush, input, 1, single-cycle request to emit the pending accumulation.
REQ-010 SHALL have port out_valid, output, 1, reduced result available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_key, output, KEY_WIDTH, key of the reduced result.
REQ-013 SHALL have port out_sum, output, VAL_WIDTH, two's-complement sum of merged values.
REQ-014 SHALL have port out_count, output, CNT_WIDTH, number of entries merged.
REQ-015 SHALL have port busy, output, 1, high when the state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE (nothing pending), ACCUM (key/sum/count pending), EMIT (result presented).
REQ-017 SHALL drive fifo_consume combinationally and SHALL never assert it while fifo_empty=1.
REQ-018 IDLE: fifo_empty=0 -> consume, load key, sum=val, count=1, go ACCUM; flush is ignored.
REQ-019 ACCUM priority 1: flush=1 -> go EMIT, no consume.
REQ-020 ACCUM priority 2: count==CNT_MAX -> go EMIT, no consume.
REQ-021 ACCUM priority 3: fifo_empty=0 and head key differs from pending key -> go EMIT, no consume; the head word stays in the FIFO.
REQ-022 ACCUM priority 4: fifo_empty=0 and key matches -> consume, sum += val (modulo 2^VAL_WIDTH, sign-wrapped, no saturation), count += 1, stay in ACCUM.
REQ-023 ACCUM with fifo_empty=1 and none of REQ-019 to REQ-020 true SHALL hold state.
REQ-024 EMIT SHALL hold out_valid=1 with out_key, out_sum, and out_count stable until out_ready=1.
REQ-025 EMIT with out_ready=1 and fifo_empty=0 SHALL consume and load the head word in the same cycle, then go ACCUM, with no idle bubble.
REQ-026 EMIT with out_ready=1 and fifo_empty=1 SHALL go IDLE.
REQ-027 flush in EMIT SHALL be ignored.
REQ-028 out_valid SHALL be registered and high only in EMIT.
REQ-029 Latency: a word popped in cycle N with flush in cycle N+1 SHALL give out_valid=1 in cycle N+2.
REQ-030 Sustained throughput SHALL be one FIFO word per cycle while keys match.

Reset
REQ-031 rst=1 SHALL force IDLE, out_valid=0, out_key=0, out_sum=0, out_count=0, and busy=0 at the next clock edge.
REQ-032 rst=1 SHALL discard any pending accumulation or unaccepted result.
REQ-033 fifo_consume SHALL be 0 whenever rst=1.

Verification
REQ-034 Scenario, merge: FIFO holds key 5 with values 10, -3, 7, then flush. Required: one result, key=5, sum=14, count=3.
REQ-035 Scenario, key change: FIFO holds (5,1),(5,2),(9,4), then flush. Required: first result (5,3,2), then (9,4,1); key-9 word popped only after the first handshake.
REQ-036 Scenario, backpressure: out_ready=0 for 5 cycles while in EMIT. Required: outputs stable, no consume, then pop on the cycle out_ready=1.
REQ-037 Scenario, count limit: CNT_WIDTH=2 with 5 key-3 words of value 1. Required: results (3,3,3), then (3,2,2) after flush.
REQ-038 Scenario, wrap: VAL_WIDTH=8 with values 100 and 100 for one key. Required: out_sum = -56 (0xC8).
REQ-039 Scenario, reset mid-ACCUM after 2 merges. Required: out_valid=0 and busy=0 next cycle, and no stale result afterwards.
